// File: rtl/dc_pfreq_queue.sv
// rtl/dc_pfreq_queue.sv - DC-side prefetch request queue with tag-pipe issue and hit/miss/drop stats (optional PFQ_DEDUP_EN)

package dc_pfreq_pkg;

    localparam int LADDR_W  = 32;
    localparam int PF_CNT_W = 16;

    typedef struct packed {
        logic [LADDR_W-1:0] laddr;
    } I_pftocache_req_type;

    typedef struct packed {
        logic [PF_CNT_W-1:0] nreq;
        logic [PF_CNT_W-1:0] nhit;
        logic [PF_CNT_W-1:0] nmiss;
        logic [PF_CNT_W-1:0] ndrop;
    } PF_cache_stats_type;

endpackage

module dc_pfreq_queue
    import dc_pfreq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pftodc_req_valid,
    output logic                pftodc_req_retry,
    input  I_pftocache_req_type pftodc_req,
    output logic                pfq_tag_valid,
    input  logic                pfq_tag_retry,
    output logic [LADDR_W-1:0]  pfq_tag_laddr,
    input  logic                tag_pfq_resp_valid,
    input  logic                tag_pfq_resp_hit,
    output PF_cache_stats_type  pf_dcstats
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [LADDR_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [OCC_W-1:0]    occ_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic                rx_xfer;
    logic                dup_hit;
    logic                push;
    logic                drop;
    logic                pop;
    logic                tag_valid;
    logic                rsp_take;

    logic [CNT_W-1:0]    nreq_q;
    logic [CNT_W-1:0]    nhit_q;
    logic [CNT_W-1:0]    nmiss_q;

    // Saturating increment: an all-ones counter stays all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign fifo_full        = (occ_q == OCC_W'(DEPTH));
    assign fifo_empty       = (occ_q == '0);

    // Retry depends only on reset and registered occupancy, never on valid,
    // so a full FIFO blocks the producer even when a pop frees a slot this cycle.
    assign pftodc_req_retry = reset | fifo_full;
    assign rx_xfer          = pftodc_req_valid & ~pftodc_req_retry;
    assign push             = rx_xfer & ~dup_hit;
    assign drop             = rx_xfer & dup_hit;

`ifdef PFQ_DEDUP_EN
    logic [LADDR_W-1:0]  inflight_laddr_q;
    logic [PTR_W-1:0]    slot_off;

    // Duplicate detection against live FIFO slots and the in-flight lookup,
    // using pre-pop state so an entry leaving this cycle still matches.
    always_comb begin
        dup_hit  = 1'b0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, slot_off} < occ_q) && (mem_q[i] == pftodc_req.laddr)) begin
                dup_hit = 1'b1;
            end
        end
        if ((state_q == ST_WAIT) && (inflight_laddr_q == pftodc_req.laddr)) begin
            dup_hit = 1'b1;
        end
    end

    // Remember the address currently being looked up for duplicate compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_laddr_q <= '0;
        end else if (pop) begin
            inflight_laddr_q <= mem_q[rd_ptr_q];
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    // FIFO storage; contents need no reset because occupancy qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pftodc_req.laddr;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Issue FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue FSM: offer the head in IDLE, then wait for the single outstanding response.
    always_comb begin
        state_d   = state_q;
        tag_valid = 1'b0;
        pop       = 1'b0;
        rsp_take  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tag_valid = ~fifo_empty & ~reset;
                if (tag_valid && !pfq_tag_retry) begin
                    pop     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tag_pfq_resp_valid) begin
                    rsp_take = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pfq_tag_valid = tag_valid;
    assign pfq_tag_laddr = tag_valid ? mem_q[rd_ptr_q] : '0;

    // Request, hit and miss statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            nreq_q  <= '0;
            nhit_q  <= '0;
            nmiss_q <= '0;
        end else begin
            if (rx_xfer) begin
                nreq_q <= sat_inc(nreq_q);
            end
            if (rsp_take && tag_pfq_resp_hit) begin
                nhit_q <= sat_inc(nhit_q);
            end
            if (rsp_take && !tag_pfq_resp_hit) begin
                nmiss_q <= sat_inc(nmiss_q);
            end
        end
    end

    assign pf_dcstats.nreq  = PF_CNT_W'(nreq_q);
    assign pf_dcstats.nhit  = PF_CNT_W'(nhit_q);
    assign pf_dcstats.nmiss = PF_CNT_W'(nmiss_q);

`ifdef PFQ_DEDUP_EN
    logic [CNT_W-1:0] ndrop_q;

    // Duplicate-drop statistic.
    always_ff @(posedge clk) begin
        if (reset) begin
            ndrop_q <= '0;
        end else if (drop) begin
            ndrop_q <= sat_inc(ndrop_q);
        end
    end

    assign pf_dcstats.ndrop = PF_CNT_W'(ndrop_q);
`else
    assign pf_dcstats.ndrop = '0;
`endif

endmodule
